// File: rtl/lut_neuron_pkg.sv
// Shared types and helpers for the LUT neuron bank.
// Latency: n/a (types, constants and elaboration-time functions only).
// Backpressure: n/a.
// Contents: FSM state enum, clog2/select-width helpers, and the index-layout
// helpers that define where each neuron's address and result sit in the
// flattened buses (used by the RTL and by any reference model).
package lut_neuron_pkg;

  typedef enum logic [1:0] {
    ST_CLEAR = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2,
    ST_LOAD  = 2'd3
  } state_t;

  function automatic int clog2(input int v);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < v) r = i + 1;
    end
    return r;
  endfunction

  // Neuron-select width; a single-neuron bank still carries a 1-bit select.
  function automatic int sel_width(input int n);
    return (n <= 1) ? 1 : clog2(n);
  endfunction

  // LSB of neuron n's table address inside the input vector.
  function automatic int addr_lsb(input int n, input int addr_w);
    return n * addr_w;
  endfunction

  // LSB of input k inside one neuron's address.
  function automatic int input_lsb(input int k, input int in_bits);
    return k * in_bits;
  endfunction

  // LSB of neuron n's result inside the output vector.
  function automatic int out_lsb(input int n, input int out_bits);
    return n * out_bits;
  endfunction

endpackage

// File: rtl/lut_neuron_table.sv
// One neuron's truth table: 2^ADDR_W x OUT_BITS distributed RAM.
// Latency: 1 cycle from re/raddr to rdata; writes take effect at the clock edge.
// Backpressure: none internally; rdata holds whenever re is low.
// Ports: clk, rst (async active-low, clears only the read register);
//        we/waddr/wdata write port; re/raddr/rdata synchronous read port.
module lut_neuron_table #(
  parameter int ADDR_W   = 8,
  parameter int OUT_BITS = 2
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                we,
  input  logic [ADDR_W-1:0]   waddr,
  input  logic [OUT_BITS-1:0] wdata,
  input  logic                re,
  input  logic [ADDR_W-1:0]   raddr,
  output logic [OUT_BITS-1:0] rdata
);

  // No reset on the array itself: the bank's CLEAR sweep zeroes it.
  logic [OUT_BITS-1:0] mem [2**ADDR_W];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)    rdata <= '0;
    else if (re) rdata <= mem[raddr];
  end

endmodule

// File: rtl/lut_neuron_bank.sv
// Bank of NUM_NEURONS runtime-loadable truth tables evaluated in parallel.
// Latency: 2 cycles input accept -> out_valid; 1 vector/cycle throughput.
// Backpressure: out_ready low with a result pending freezes both stages; a
//   pending cfg_valid blocks new inputs, drains the pipe, then opens cfg_ready.
// Ports: clk, rst (async active-low); in_valid/in_ready/in_data input vectors;
//   out_valid/out_ready/out_data results; cfg_valid/cfg_ready/cfg_sel/cfg_addr/
//   cfg_data/cfg_last table-write stream; busy (not in RUN); cfg_err (sticky).
module lut_neuron_bank
  import lut_neuron_pkg::*;
#(
  parameter  int FAN_IN      = 4,
  parameter  int IN_BITS     = 2,
  parameter  int OUT_BITS    = 2,
  parameter  int NUM_NEURONS = 4,
  localparam int ADDR_W      = FAN_IN * IN_BITS,
  localparam int NSEL_W      = sel_width(NUM_NEURONS)
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            in_valid,
  output logic                            in_ready,
  input  logic [NUM_NEURONS*ADDR_W-1:0]   in_data,
  output logic                            out_valid,
  input  logic                            out_ready,
  output logic [NUM_NEURONS*OUT_BITS-1:0] out_data,
  input  logic                            cfg_valid,
  output logic                            cfg_ready,
  input  logic [NSEL_W-1:0]               cfg_sel,
  input  logic [ADDR_W-1:0]               cfg_addr,
  input  logic [OUT_BITS-1:0]             cfg_data,
  input  logic                            cfg_last,
  output logic                            busy,
  output logic                            cfg_err
);

  state_t                          state, state_nxt;
  logic [ADDR_W-1:0]               clear_cnt;
  logic                            s1_valid, s2_valid;
  logic [NUM_NEURONS*ADDR_W-1:0]   s1_addr;
  logic                            stall, accept, cfg_fire, sel_oor, rd_en;

  assign stall     = s2_valid & ~out_ready;
  assign in_ready  = (state == ST_RUN) & ~stall & ~cfg_valid;
  assign accept    = in_valid & in_ready;
  assign cfg_ready = (state == ST_LOAD);
  assign cfg_fire  = cfg_valid & cfg_ready;
  assign busy      = (state != ST_RUN);
  assign out_valid = s2_valid;
  assign rd_en     = s1_valid & ~stall;

  // A power-of-two bank decodes every select value, so no range check exists.
  if ((1 << NSEL_W) == NUM_NEURONS) begin : g_sel_full
    assign sel_oor = 1'b0;
  end else begin : g_sel_part
    assign sel_oor = (cfg_sel >= NSEL_W'(NUM_NEURONS));
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_CLEAR: if (clear_cnt == '1)            state_nxt = ST_RUN;
      ST_RUN:   if (cfg_valid)                  state_nxt = ST_DRAIN;
      ST_DRAIN: if (!s1_valid && !s2_valid)     state_nxt = ST_LOAD;
      ST_LOAD:  if (cfg_fire && cfg_last)       state_nxt = ST_RUN;
      default:                                  state_nxt = ST_CLEAR;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= ST_CLEAR;
      clear_cnt <= '0;
      s1_valid  <= 1'b0;
      s2_valid  <= 1'b0;
      s1_addr   <= '0;
      cfg_err   <= 1'b0;
    end else begin
      state <= state_nxt;
      if (state == ST_CLEAR) clear_cnt <= clear_cnt + 1'b1;
      if (!stall) begin
        s1_valid <= accept;
        s2_valid <= s1_valid;
      end
      if (accept) s1_addr <= in_data;
      if (cfg_fire && sel_oor) cfg_err <= 1'b1;
    end
  end

  // During CLEAR every table is written with zero at clear_cnt; in LOAD only
  // the selected, in-range table takes the beat.
  for (genvar n = 0; n < NUM_NEURONS; n++) begin : g_tbl
    logic                we_n;
    logic [ADDR_W-1:0]   waddr_n;
    logic [OUT_BITS-1:0] wdata_n;

    assign we_n    = (state == ST_CLEAR) |
                     (cfg_fire & ~sel_oor & (cfg_sel == NSEL_W'(n)));
    assign waddr_n = (state == ST_CLEAR) ? clear_cnt : cfg_addr;
    assign wdata_n = (state == ST_CLEAR) ? '0 : cfg_data;

    lut_neuron_table #(
      .ADDR_W   (ADDR_W),
      .OUT_BITS (OUT_BITS)
    ) u_tbl (
      .clk   (clk),
      .rst   (rst),
      .we    (we_n),
      .waddr (waddr_n),
      .wdata (wdata_n),
      .re    (rd_en),
      .raddr (s1_addr[addr_lsb(n, ADDR_W) +: ADDR_W]),
      .rdata (out_data[out_lsb(n, OUT_BITS) +: OUT_BITS])
    );
  end

endmodule
